// File: rtl/alu_sout_rx.sv
// alu_sout_rx: host-side receiver for the ALU serial output line.
// Deserialises 11-bit frames (start, type, 8 payload bits MSB first, stop),
// assembles DATA_FRAMES data bytes plus one CTL byte into a result word with
// flags, and decodes single-frame error responses.
// Optional feature macro: ALU_SOUT_RX_CRC_CHECK_EN builds the CRC3 checker;
// without it crc_ok is tied high and the received crc bits are ignored.
module alu_sout_rx #(
   parameter int DATA_FRAMES    = 4,
   parameter int TIMEOUT_CYCLES = 64
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     sout,
   output logic                     result_valid,
   output logic [8*DATA_FRAMES-1:0] result,
   output logic [3:0]               flags,
   output logic                     crc_ok,
   output logic                     err_valid,
   output logic [5:0]               err_flags,
   output logic                     parity_ok,
   output logic                     frame_err
);

   localparam int CW    = 8 * DATA_FRAMES;
   localparam int CNT_W = $clog2(DATA_FRAMES + 1);
   localparam int TO_W  = $clog2(TIMEOUT_CYCLES + 1);

   localparam logic [2:0] S_IDLE      = 3'd0;
   localparam logic [2:0] S_TYPE      = 3'd1;
   localparam logic [2:0] S_DATA      = 3'd2;
   localparam logic [2:0] S_STOP      = 3'd3;
   localparam logic [2:0] S_STOP_WAIT = 3'd4;

   logic [2:0]       state;
   logic             is_ctl;
   logic [7:0]       shreg;
   logic [2:0]       bit_cnt;
   logic [CNT_W-1:0] byte_cnt;
   logic [CW-1:0]    c_shift;
   logic [TO_W-1:0]  idle_cnt;
   logic             full;

   assign full = (byte_cnt == CNT_W'(DATA_FRAMES));

`ifdef ALU_SOUT_RX_CRC_CHECK_EN
   // CRC3, polynomial x^3+x+1, init 0, over {C, 1'b0, flags} MSB first
   function automatic logic [2:0] crc3(input logic [CW-1:0] c, input logic [3:0] f);
      logic [CW+4:0] msg;
      logic [2:0]    crc;
      logic          fb;
      msg = {c, 1'b0, f};
      crc = 3'b000;
      for (int i = CW + 4; i >= 0; i--) begin
         fb  = crc[2] ^ msg[i];
         crc = {crc[1], crc[0] ^ fb, fb};
      end
      return crc;
   endfunction

   // crc_ok is captured together with a good normal response
   always_ff @(posedge clk) begin
      if (rst)
         crc_ok <= 1'b0;
      else if (state == S_STOP && sout && is_ctl && !shreg[7] && full)
         crc_ok <= (crc3(c_shift, shreg[6:3]) == shreg[2:0]);
   end
`else
   assign crc_ok = 1'b1;
`endif

   // Frame FSM, byte assembly, response decode and inter-frame timeout
   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= S_IDLE;
         is_ctl       <= 1'b0;
         shreg        <= '0;
         bit_cnt      <= '0;
         byte_cnt     <= '0;
         c_shift      <= '0;
         idle_cnt     <= '0;
         result_valid <= 1'b0;
         result       <= '0;
         flags        <= '0;
         err_valid    <= 1'b0;
         err_flags    <= '0;
         parity_ok    <= 1'b0;
         frame_err    <= 1'b0;
      end else begin
         result_valid <= 1'b0;
         err_valid    <= 1'b0;
         frame_err    <= 1'b0;
         idle_cnt     <= '0;
         case (state)
            S_IDLE: begin
               if (!sout) begin
                  state <= S_TYPE;
               end else if (byte_cnt != '0) begin
                  // Partial response waiting on the line: abort once it stalls too long
                  if (idle_cnt == TO_W'(TIMEOUT_CYCLES - 1)) begin
                     frame_err <= 1'b1;
                     byte_cnt  <= '0;
                  end else begin
                     idle_cnt  <= idle_cnt + 1'b1;
                  end
               end
            end
            S_TYPE: begin
               is_ctl  <= sout;
               bit_cnt <= 3'd7;
               state   <= S_DATA;
            end
            S_DATA: begin
               shreg <= {shreg[6:0], sout};
               if (bit_cnt == 3'd0)
                  state <= S_STOP;
               else
                  bit_cnt <= bit_cnt - 1'b1;
            end
            S_STOP: begin
               if (!sout) begin
                  // Broken stop bit: wait for the line to go high before hunting a start
                  frame_err <= 1'b1;
                  byte_cnt  <= '0;
                  state     <= S_STOP_WAIT;
               end else begin
                  state <= S_IDLE;
                  if (!is_ctl) begin
                     if (full) begin
                        frame_err <= 1'b1;
                        byte_cnt  <= '0;
                     end else begin
                        c_shift  <= {c_shift[CW-9:0], shreg};
                        byte_cnt <= byte_cnt + 1'b1;
                     end
                  end else if (shreg[7]) begin
                     err_valid <= 1'b1;
                     err_flags <= shreg[6:1];
                     parity_ok <= ~^shreg;
                     byte_cnt  <= '0;
                  end else if (!full) begin
                     frame_err <= 1'b1;
                     byte_cnt  <= '0;
                  end else begin
                     result_valid <= 1'b1;
                     result       <= c_shift;
                     flags        <= shreg[6:3];
                     byte_cnt     <= '0;
                  end
               end
            end
            S_STOP_WAIT: begin
               if (sout)
                  state <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_alu_sout_rx.sv
// Bench for alu_sout_rx: frames are driven on sout, a behavioural model
// predicts each response event into a queue, and a monitor compares every
// output pulse against the head of that queue.
module tb_alu_sout_rx;

   localparam int DF  = 4;
   localparam int TMO = 64;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        sout = 1'b1;
   logic        result_valid;
   logic [31:0] result;
   logic [3:0]  flags;
   logic        crc_ok;
   logic        err_valid;
   logic [5:0]  err_flags;
   logic        parity_ok;
   logic        frame_err;

   alu_sout_rx #(.DATA_FRAMES(DF), .TIMEOUT_CYCLES(TMO)) dut (
      .clk(clk), .rst(rst), .sout(sout),
      .result_valid(result_valid), .result(result), .flags(flags), .crc_ok(crc_ok),
      .err_valid(err_valid), .err_flags(err_flags), .parity_ok(parity_ok),
      .frame_err(frame_err)
   );

   always #5 clk = ~clk;

   typedef struct {
      int          kind;     // 1 result, 2 error response, 3 frame fault
      logic [31:0] res;
      logic [3:0]  flg;
      logic        crc;
      logic [5:0]  eflg;
      logic        par;
   } ev_t;

   ev_t         exp_q[$];
   logic [7:0]  model_bytes[$];
   logic [31:0] last_res;
   logic [3:0]  last_flg;
   int          idle_run;
   int          n_cmp = 0;
   int          n_bad = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference CRC: remainder of (message * x^3) divided by x^3+x+1
   function automatic logic [2:0] crc_div(input logic [36:0] msg);
      logic [39:0] r;
      r = {msg, 3'b000};
      for (int i = 39; i >= 3; i--)
         if (r[i]) r[i -: 4] = r[i -: 4] ^ 4'b1011;
      return r[2:0];
   endfunction

   function automatic logic [2:0] golden_crc(input logic [31:0] c, input logic [3:0] f);
      return crc_div({c, 1'b0, f});
   endfunction

   task automatic push_fe();
      ev_t e;
      e = '{3, 32'h0, 4'h0, 1'b0, 6'h0, 1'b0};
      exp_q.push_back(e);
   endtask

   // Apply the receiver rules to one complete frame
   task automatic model_frame(input logic t, input logic [7:0] b, input logic stp);
      ev_t e;
      logic [31:0] c;
      idle_run = 0;
      if (!stp) begin
         push_fe();
         model_bytes.delete();
      end else if (!t) begin
         if (model_bytes.size() == DF) begin
            push_fe();
            model_bytes.delete();
         end else begin
            model_bytes.push_back(b);
         end
      end else if (b[7]) begin
         e = '{2, last_res, last_flg, 1'b0, b[6:1], ~^b};
         exp_q.push_back(e);
         model_bytes.delete();
      end else if (model_bytes.size() != DF) begin
         push_fe();
         model_bytes.delete();
      end else begin
         c = {model_bytes[0], model_bytes[1], model_bytes[2], model_bytes[3]};
`ifdef ALU_SOUT_RX_CRC_CHECK_EN
         e = '{1, c, b[6:3], b[2:0] == golden_crc(c, b[6:3]), 6'h0, 1'b0};
`else
         e = '{1, c, b[6:3], 1'b1, 6'h0, 1'b0};
`endif
         exp_q.push_back(e);
         last_res = c;
         last_flg = b[6:3];
         model_bytes.delete();
      end
   endtask

   task automatic drive_bit(input logic v);
      @(posedge clk);
      #1 sout = v;
   endtask

   task automatic send_frame(input logic t, input logic [7:0] b, input logic stp = 1'b1);
      drive_bit(1'b0);
      drive_bit(t);
      for (int i = 7; i >= 0; i--) drive_bit(b[i]);
      model_frame(t, b, stp);
      drive_bit(stp);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin
         drive_bit(1'b1);
         idle_run++;
         if (model_bytes.size() != 0 && idle_run == TMO) begin
            push_fe();
            model_bytes.delete();
         end
      end
   endtask

   task automatic send_response(input logic [31:0] c, input logic [7:0] ctl);
      for (int i = 3; i >= 0; i--) send_frame(1'b0, c[8*i +: 8]);
      send_frame(1'b1, ctl);
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_result_valid"}, result_valid, 0);
      check({tag, "_result"}, result, 0);
      check({tag, "_flags"}, flags, 0);
      check({tag, "_err_valid"}, err_valid, 0);
      check({tag, "_err_flags"}, err_flags, 0);
      check({tag, "_parity_ok"}, parity_ok, 0);
      check({tag, "_frame_err"}, frame_err, 0);
`ifdef ALU_SOUT_RX_CRC_CHECK_EN
      check({tag, "_crc_ok"}, crc_ok, 0);
`else
      check({tag, "_crc_ok"}, crc_ok, 1);
`endif
   endtask

   // Monitor: every output pulse must match the oldest predicted event
   initial begin
      ev_t e;
      int  k;
      forever begin
         @(negedge clk);
         if (!rst && (result_valid || err_valid || frame_err)) begin
            check("one_pulse", 64'(result_valid) + 64'(err_valid) + 64'(frame_err), 1);
            k = result_valid ? 1 : (err_valid ? 2 : 3);
            if (exp_q.size() == 0) begin
               check("unexpected_pulse_kind", k, 0);
            end else begin
               e = exp_q.pop_front();
               check("kind", k, e.kind);
               if (k == 1 && e.kind == 1) begin
                  check("result", result, e.res);
                  check("flags", flags, e.flg);
                  check("crc_ok", crc_ok, e.crc);
               end else if (k == 2 && e.kind == 2) begin
                  check("err_flags", err_flags, e.eflg);
                  check("parity_ok", parity_ok, e.par);
                  check("held_result", result, e.res);
                  check("held_flags", flags, e.flg);
               end
            end
         end
      end
   end

   initial begin
      logic [31:0] c;
      logic [7:0]  ctl;
      int          sel;
      last_res = '0;
      last_flg = '0;
      idle_run = 0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check_reset_outputs("reset");
      @(posedge clk);
      #1 rst = 1'b0;
      idle(3);

      // All-zero response
      send_response(32'h0, 8'h00);
      idle(4);
      // Corrupted CRC
      c = 32'h12345678;
      send_response(c, {1'b0, 4'b1010, golden_crc(c, 4'b1010) ^ 3'b001});
      idle(2);
      // Good CRC, back-to-back
      c = 32'h87654321;
      send_response(c, {1'b0, 4'b0101, golden_crc(c, 4'b0101)});
      // Error responses
      send_frame(1'b1, 8'hC9);
      idle(2);
      send_frame(1'b1, 8'hC8);
      idle(2);
      // Short response, then an overlong one, then a lone normal CTL
      for (int i = 0; i < 3; i++) send_frame(1'b0, 8'(i + 1));
      send_frame(1'b1, 8'h00);
      for (int i = 0; i < 5; i++) send_frame(1'b0, 8'(8'hA0 + i));
      send_frame(1'b1, 8'h00);
      idle(2);
      // Broken stop bit, then recovery
      send_frame(1'b0, 8'h55, 1'b0);
      idle(2);
      c = 32'hDEADBEEF;
      send_response(c, {1'b0, 4'b1001, golden_crc(c, 4'b1001)});
      idle(2);
      // Stalled partial response
      send_frame(1'b0, 8'h11);
      send_frame(1'b0, 8'h22);
      idle(80);
      // Reset in the middle of a frame
      send_frame(1'b0, 8'h33);
      drive_bit(1'b0);
      drive_bit(1'b0);
      drive_bit(1'b1);
      #1 rst = 1'b1;
      model_bytes.delete();
      last_res = '0;
      last_flg = '0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check_reset_outputs("midreset");
      @(posedge clk);
      #1 begin rst = 1'b0; sout = 1'b1; end
      idle(2);
      c = 32'hCAFEF00D;
      send_response(c, {1'b0, 4'b0011, golden_crc(c, 4'b0011)});
      idle(2);

      // Randomised mix of responses
      for (int n = 0; n < 40; n++) begin
         sel = $urandom_range(0, 9);
         c   = $urandom;
         ctl = 8'($urandom);
         if (sel < 5) begin
            ctl[7] = 1'b0;
            if ($urandom_range(0, 1) == 1) ctl[2:0] = golden_crc(c, ctl[6:3]);
            send_response(c, ctl);
         end else if (sel < 7) begin
            ctl[7] = 1'b1;
            for (int i = 0; i < $urandom_range(0, 3); i++) send_frame(1'b0, 8'($urandom));
            send_frame(1'b1, ctl);
         end else if (sel == 7) begin
            ctl[7] = 1'b0;
            for (int i = 0; i < $urandom_range(0, 5); i++)
               if (i != DF) send_frame(1'b0, 8'($urandom));
            send_frame(1'b1, ctl);
         end else if (sel == 8) begin
            send_frame(1'b0, 8'($urandom), 1'b0);
            idle(1);
         end else begin
            for (int i = 0; i < 6; i++) send_frame(1'b0, 8'($urandom));
            send_frame(1'b1, ctl & 8'h7F);
         end
         idle($urandom_range(0, 6));
      end

      idle(10);
      check("pending_events", exp_q.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
